mux16_scan_ctrl: RTL and testbench



---
 rtl/mux16_scan_ctrl_pkg.sv | 18 +
 rtl/mux16_sel.sv | 23 ++
 rtl/mux16_scan_ctrl.sv | 95 +++++++++
 tb/tb_mux16_scan_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mux16_scan_ctrl_pkg.sv
// Shared types and constants for the 16-channel scan controller and its selector.
// Provides the FSM state encoding, default geometry and the scan start-index helper.
package mux16_scan_ctrl_pkg;

    localparam int NCH_DEF  = 16;
    localparam int SELW_DEF = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // First select index of a scan: top channel when scanning downward, else channel 0.
    function automatic int start_index(input int msb_first, input int nch);
        return (msb_first != 0) ? (nch - 1) : 0;
    endfunction

endpackage

// File: rtl/mux16_sel.sv
// NCH:1 bit selector that sits beside the scan controller.
// One-hot AND-OR form keeps it purely combinational from data/sel.
module mux16_sel #(
    parameter int NCH  = 16,
    parameter int SELW = 4
) (
    input  logic [NCH-1:0]  data,
    input  logic [SELW-1:0] sel,
    output logic            y
);

    logic [NCH-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_hit
            assign hit[gi] = data[gi] & (sel == SELW'(gi));
        end
    endgenerate

    assign y = |hit;

endmodule

// File: rtl/mux16_scan_ctrl.sv
// Parallel-to-serial scan controller: latches a word, steps the selector select
// through every channel and forwards the selected bit as a valid/ready stream.
module mux16_scan_ctrl
    import mux16_scan_ctrl_pkg::*;
#(
    parameter int NCH       = NCH_DEF,
    parameter int SELW      = SELW_DEF,
    parameter int MSB_FIRST = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [NCH-1:0]  mux_in,
    output logic [SELW-1:0] mux_sel,
    input  logic            mux_out,
    output logic            ser_bit,
    output logic            ser_valid,
    input  logic            ser_ready,
    output logic            ser_last,
    output logic            done
);

    localparam logic [SELW-1:0] START_IDX = SELW'(start_index(MSB_FIRST, NCH));
    localparam logic [SELW-1:0] LAST_CNT  = SELW'(NCH - 1);
    localparam logic [SELW-1:0] SEL_STEP  = SELW'(1);

    state_t          state_reg, state_next;
    logic [NCH-1:0]  mux_in_reg, mux_in_next;
    logic [SELW-1:0] mux_sel_reg, mux_sel_next;
    logic [SELW-1:0] cnt_reg, cnt_next;
    logic            done_reg, done_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            mux_in_reg  <= '0;
            mux_sel_reg <= START_IDX;
            cnt_reg     <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mux_in_reg  <= mux_in_next;
            mux_sel_reg <= mux_sel_next;
            cnt_reg     <= cnt_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        mux_in_next  = mux_in_reg;
        mux_sel_next = mux_sel_reg;
        cnt_next     = cnt_reg;
        done_next    = 1'b0;
        in_ready     = 1'b0;
        ser_valid    = 1'b0;
        ser_last     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mux_in_next  = in_data;
                    mux_sel_next = START_IDX;
                    cnt_next     = '0;
                    state_next   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                ser_valid = 1'b1;
                ser_last  = (cnt_reg == LAST_CNT);
                // Select and count only move on an accepted beat, so a stall freezes ser_bit.
                if (ser_ready) begin
                    cnt_next     = cnt_reg + SEL_STEP;
                    mux_sel_next = (MSB_FIRST != 0) ? (mux_sel_reg - SEL_STEP)
                                                    : (mux_sel_reg + SEL_STEP);
                    if (ser_last) begin
                        state_next   = ST_IDLE;
                        mux_sel_next = START_IDX;
                        done_next    = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign mux_in  = mux_in_reg;
    assign mux_sel = mux_sel_reg;
    assign ser_bit = mux_out;
    assign done    = done_reg;

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Bench for mux16_scan_ctrl: an LSB-first and an MSB-first controller, each with
// its selector, share one stimulus and are checked beat by beat against the word.
module tb_mux16_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        ser_ready;

    logic        in_ready_l, ser_bit_l, ser_valid_l, ser_last_l, done_l, mux_out_l;
    logic [15:0] mux_in_l;
    logic [3:0]  mux_sel_l;
    logic        in_ready_m, ser_bit_m, ser_valid_m, ser_last_m, done_m, mux_out_m;
    logic [15:0] mux_in_m;
    logic [3:0]  mux_sel_m;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux16_scan_ctrl #(.NCH(16), .SELW(4), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
        .mux_in(mux_in_l), .mux_sel(mux_sel_l), .mux_out(mux_out_l), .ser_bit(ser_bit_l),
        .ser_valid(ser_valid_l), .ser_ready(ser_ready), .ser_last(ser_last_l), .done(done_l)
    );
    mux16_sel #(.NCH(16), .SELW(4)) u_sel_l (.data(mux_in_l), .sel(mux_sel_l), .y(mux_out_l));

    mux16_scan_ctrl #(.NCH(16), .SELW(4), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_m),
        .mux_in(mux_in_m), .mux_sel(mux_sel_m), .mux_out(mux_out_m), .ser_bit(ser_bit_m),
        .ser_valid(ser_valid_m), .ser_ready(ser_ready), .ser_last(ser_last_m), .done(done_m)
    );
    mux16_sel #(.NCH(16), .SELW(4)) u_sel_m (.data(mux_in_m), .sel(mux_sel_m), .y(mux_out_m));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a word and wait (bounded) until it is taken; returns at the first scan cycle.
    task automatic accept(input logic [15:0] word, input logic hold);
        int n = 0;
        in_data  = word;
        in_valid = 1'b1;
        while (!in_ready_l && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 100), 32'd1);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        $display("word %04h accepted at %0t", word, $time);
    endtask

    // Model: beat k of a word is word[k] on sel k (LSB-first) and word[15-k] on sel 15-k (MSB-first).
    // mode 0: always ready, 1: ready 1,0,0,1 repeating, 2: random ready.
    task automatic scan_word(input logic [15:0] word, input int mode, input int nbeats);
        int   k = 0;
        int   cyc = 0;
        logic rdy;
        logic stalled = 1'b0;
        logic [3:0] ps_l = '0, ps_m = '0;
        logic pb_l = 1'b0, pb_m = 1'b0;
        while (k < nbeats && cyc < 400) begin
            chk("valid_l", 32'(ser_valid_l), 32'd1);
            chk("valid_m", 32'(ser_valid_m), 32'd1);
            chk("in_ready_busy", 32'(in_ready_l), 32'd0);
            chk("mux_in_held_l", 32'(mux_in_l), 32'(word));
            chk("done_busy", 32'(done_l | done_m), 32'd0);
            if (stalled) begin
                chk("stall_sel_l", 32'(mux_sel_l), 32'(ps_l));
                chk("stall_sel_m", 32'(mux_sel_m), 32'(ps_m));
                chk("stall_bit_l", 32'(ser_bit_l), 32'(pb_l));
                chk("stall_bit_m", 32'(ser_bit_m), 32'(pb_m));
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(1, 0));
            endcase
            ser_ready = rdy;
            in_data   = 16'($urandom);
            if (rdy) begin
                chk("bit_l", 32'(ser_bit_l), 32'(word[k]));
                chk("sel_l", 32'(mux_sel_l), 32'(k));
                chk("last_l", 32'(ser_last_l), 32'(k == 15));
                chk("bit_m", 32'(ser_bit_m), 32'(word[15-k]));
                chk("sel_m", 32'(mux_sel_m), 32'(15 - k));
                chk("last_m", 32'(ser_last_m), 32'(k == 15));
                k++;
            end else begin
                ps_l = mux_sel_l; ps_m = mux_sel_m;
                pb_l = ser_bit_l; pb_m = ser_bit_m;
            end
            stalled = !rdy;
            @(negedge clk);
            cyc++;
        end
        ser_ready = 1'b0;
        chk("scan_timeout", 32'(k), 32'(nbeats));
        if (mode == 0 && nbeats == 16) chk("scan_cycles", 32'(cyc), 32'd16);
        $display("word %04h mode %0d: %0d beats in %0d cycles", word, mode, k, cyc);
    endtask

    // Called in the cycle after the final beat is accepted.
    task automatic check_done();
        chk("done_l", 32'(done_l), 32'd1);
        chk("done_m", 32'(done_m), 32'd1);
        chk("in_ready_done", 32'(in_ready_l & in_ready_m), 32'd1);
        chk("valid_done", 32'(ser_valid_l | ser_valid_m), 32'd0);
        chk("sel_done_l", 32'(mux_sel_l), 32'd0);
        chk("sel_done_m", 32'(mux_sel_m), 32'd15);
        if (!in_valid) begin
            @(negedge clk);
            chk("done_pulse_l", 32'(done_l), 32'd0);
            chk("done_pulse_m", 32'(done_m), 32'd0);
        end
    endtask

    initial begin
        logic [15:0] w;
        rst = 1'b1; in_valid = 1'b0; ser_ready = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready_l & in_ready_m), 32'd1);
        chk("rst_valid", 32'(ser_valid_l | ser_valid_m), 32'd0);
        chk("rst_last", 32'(ser_last_l | ser_last_m), 32'd0);
        chk("rst_sel_l", 32'(mux_sel_l), 32'd0);
        chk("rst_sel_m", 32'(mux_sel_m), 32'd15);
        chk("rst_done", 32'(done_l | done_m), 32'd0);
        chk("rst_mux_in", 32'(mux_in_l), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        accept(16'hA5C3, 1'b0);
        scan_word(16'hA5C3, 0, 16);
        check_done();

        accept(16'h8001, 1'b0);
        scan_word(16'h8001, 1, 16);
        check_done();

        // Back-to-back: second word taken in the done cycle.
        accept(16'hFFFF, 1'b1);
        scan_word(16'hFFFF, 0, 16);
        in_data = 16'h0000;
        check_done();
        @(negedge clk);
        in_valid = 1'b0;
        scan_word(16'h0000, 0, 16);
        check_done();

        for (int i = 0; i < 6; i++) begin
            w = 16'($urandom);
            repeat ($urandom_range(3, 0)) @(negedge clk);
            accept(w, 1'b0);
            scan_word(w, 2, 16);
            check_done();
        end

        // Reset after the 5th accepted beat discards the scan without a done pulse.
        accept(16'h1234, 1'b0);
        scan_word(16'h1234, 0, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", 32'(ser_valid_l | ser_valid_m), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready_l & in_ready_m), 32'd1);
        chk("mid_rst_sel_l", 32'(mux_sel_l), 32'd0);
        chk("mid_rst_sel_m", 32'(mux_sel_m), 32'd15);
        chk("mid_rst_done", 32'(done_l | done_m), 32'd0);
        chk("mid_rst_mux_in", 32'(mux_in_l), 32'd0);
        @(negedge clk);
        chk("mid_rst_no_done", 32'(done_l | done_m), 32'd0);
        $display("reset mid-scan checked at %0t", $time);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
